// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic issue stage: op encodings, FSM
// state constants and the command record carried through the FIFO.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Issue FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_OUT  = 2'd2;

    // Command record for the default 8-bit datapath, laid out {a, b, sel}
    // exactly as the FIFO word is packed inside arith_issue.
    localparam int ARITH_W = 8;
    typedef struct packed {
        logic [ARITH_W-1:0] a;
        logic [ARITH_W-1:0] b;
        logic [1:0]         sel;
    } cmd_t;

endpackage

// File: rtl/arith_cmd_fifo.sv
// Command FIFO for arith_issue. DEPTH entries (power of two), pointers wrap
// naturally. A push is refused whenever the FIFO is full, even if a pop
// happens in the same cycle (no pass-through when full).
module arith_cmd_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import arith_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arith_issue.sv
// Operand issue stage for the arithmetic unit. Commands are queued in a
// FIFO, issued one at a time on registered alu_* operands, and the unit's
// combinational result is captured and offered downstream.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// out_valid, once high, stays high with stable payload until out_ready.
// Optional feature macro: ARITH_DIVZERO_CHECK_EN (divide-by-zero override).
module arith_issue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [1:0]                 in_sel,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [1:0]                 alu_sel,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [1:0]                 out_sel,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    import arith_pkg::*;

    localparam int DW = 2*WIDTH + 2;

    state_t        state;
    logic [DW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_req;
    logic          do_pop;
    logic [WIDTH-1:0] cap_result;
    logic          cap_err;

    // Pop whenever the operand registers are free: idle, or the held result
    // is being accepted this cycle.
    assign pop_req  = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
    assign do_pop   = pop_req && !fifo_empty;
    assign in_ready = !fifo_full;

    arith_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data ({in_a, in_b, in_sel}),
        .pop       (do_pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Result capture value, with optional divide-by-zero override.
    always_comb begin
        cap_result = alu_result;
        cap_err    = 1'b0;
`ifdef ARITH_DIVZERO_CHECK_EN
        if ((alu_sel == OP_DIV) && (alu_b == '0)) begin
            cap_result = '1;
            cap_err    = 1'b1;
        end
`endif
    end

    // Issue FSM together with operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= OP_ADD;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sel    <= OP_ADD;
            out_err    <= 1'b0;
        end else begin
            if (do_pop) begin
                alu_a   <= head[DW-1 -: WIDTH];
                alu_b   <= head[WIDTH+1 -: WIDTH];
                alu_sel <= head[1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    out_result <= cap_result;
                    out_sel    <= alu_sel;
                    out_err    <= cap_err;
                    out_valid  <= 1'b1;
                    state      <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= fifo_empty ? ST_IDLE : ST_EXEC;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arith_issue.md
# arith_issue

Operand issue stage for the 8-bit arithmetic unit.
- Accepts arithmetic commands (a, b, sel) over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered operands to the combinational arithmetic unit one command at a time, captures its result, and presents it downstream with a valid/ready handshake.
- Sits directly upstream of the arithmetic unit and owns all sequencing around it.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must match the arithmetic unit.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_sel  in  2  op: 00 add, 01 sub, 10 mul, 11 div.
- alu_a  out  WIDTH  registered operand a to the arithmetic unit.
- alu_b  out  WIDTH  registered operand b to the arithmetic unit.
- alu_sel  out  2  registered op select to the arithmetic unit.
- alu_result  in  WIDTH  combinational result from the arithmetic unit.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  captured result.
- out_sel  out  2  op that produced out_result.
- out_err  out  1  divide-by-zero flag.
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Push when in_valid && in_ready. There is no pass-through when full: a push is never accepted while count == DEPTH, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_sel and go to EXEC; otherwise stay.
  - EXEC: operands are stable. Capture alu_result into out_result, copy alu_sel into out_sel, compute out_err, go to OUT.
  - OUT: out_valid = 1. Hold out_result, out_sel and out_err stable until out_ready. On accept, if the FIFO is non-empty, pop the next entry and go to EXEC; otherwise go to IDLE.
- alu_* registers change only on a pop. They hold their last value while idle.
- out_valid is 1 only in OUT. It is a registered output.
- Arithmetic is performed entirely by the arithmetic unit. This block does no widening or truncation; results are WIDTH bits, modulo 2^WIDTH as returned.

## Timing
- Reset values: in_ready 1, out_valid 0, alu_a 0, alu_b 0, alu_sel 00, out_result 0, out_sel 00, out_err 0, fifo_count 0, state IDLE.
- Latency:
  - Push at edge t into an empty FIFO while IDLE gives the pop at edge t+1 and out_valid high after edge t+2.
  - Throughput with out_ready held high is one result per 2 cycles; out_valid is high every other cycle.
- Capacity: with the output stalled, DEPTH+1 commands are accepted (one held in the operand registers, DEPTH in the FIFO).
- Reset asserted mid-operation forces all outputs to their reset values immediately. FIFO contents are discarded. No stale result appears after release.
- Back-pressure: out_valid is never withdrawn before out_ready is sampled high.

## Configuration
- ARITH_DIVZERO_CHECK_EN defined:
  - In EXEC, if alu_sel == 11 and alu_b == 0, out_result = all ones and out_err = 1. The arithmetic unit's output is ignored for that command.
  - All other commands give out_err = 0.
- ARITH_DIVZERO_CHECK_EN not defined:
  - out_result = alu_result for every op.
  - out_err is tied to 0. The port remains present.

## Structure
- Package arith_pkg holds:
  - op encodings OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
  - the FSM state typedef (IDLE, EXEC, OUT);
  - a packed command struct {a, b, sel}.
- Sub-module arith_cmd_fifo contains the command FIFO: DEPTH entries, push/pop, count, full/empty. The FSM and output registers stay in arith_issue.

## Test plan
- Reset: hold rst_n low, then release -> in_ready = 1, out_valid = 0, alu_sel = 00, fifo_count = 0.
- Single add: push a=3, b=5, sel=00 with out_ready=1 and a bench model of the arithmetic unit -> out_valid after 2 edges, out_result = 8, out_sel = 00, out_err = 0.
- Fill and stall: out_ready=0, offer 6 commands back-to-back -> 5 accepted, in_ready = 0 with fifo_count = 4, sixth held. Then raise out_ready -> all 5 results delivered in order, each held stable until accepted.
- Back-to-back: queue sub 10-3, then mul 4*5, with out_ready=1 -> results 7 then 20, with out_valid high on alternating cycles.
- Divide by zero: a=9, b=0, sel=11 -> with the macro defined, out_result = 8'hFF and out_err = 1; without it, out_result equals the model's output and out_err = 0. Also a=9, b=3 -> 3 with out_err = 0.
- Reset mid-op: drop rst_n while in OUT with 2 commands queued -> out_valid falls immediately and fifo_count = 0; after release, no output until a new push.
